// File: rtl/quad_count_ctrl.sv
// quad_count_ctrl: quadrature encoder front end for a cascaded sn74ls669 chain.
// The two asynchronous encoder phases are synchronised, filtered and decoded into
// registered count strobes. Illegal (two-bit) transitions are flagged, and synchronous
// clear requests become load pulses.
// Ports:
//   CLOCK, RESETn     : clock; asynchronous active-low reset
//   PHASE_A, PHASE_B  : asynchronous encoder phases
//   CLEAR             : synchronous request to load zero into the counter chain
//   ERR_CLR           : synchronous clear of ERROR
//   CNT_ENn           : active-low single-cycle count strobe
//   U_Dn              : direction level (1 = up, 0 = down)
//   LOADn             : active-low synchronous load (counter DATA pins tied to 0)
//   ERROR             : sticky illegal-transition flag
module quad_count_ctrl #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic CLOCK,
  input  logic RESETn,
  input  logic PHASE_A,
  input  logic PHASE_B,
  input  logic CLEAR,
  input  logic ERR_CLR,
  output logic CNT_ENn,
  output logic U_Dn,
  output logic LOADn,
  output logic ERROR
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] FILT_MAX = RUN_W'(FILTER_LEN);
  localparam bit FILT_ONE = (FILTER_LEN <= 1);

  // State encoding: the low two bits are {fA,fB}; bit 2 marks INIT.
  localparam logic [2:0] ST_INIT = 3'b100;
  localparam logic [2:0] ST_S00  = 3'b000;
  localparam logic [2:0] ST_S01  = 3'b001;
  localparam logic [2:0] ST_S11  = 3'b011;
  localparam logic [2:0] ST_S10  = 3'b010;

  // Channel index 1 is phase A and index 0 is phase B.
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            filt;
  logic [1:0]            valid;
  logic [1:0][RUN_W-1:0] run;

  logic [2:0] state;
  logic [2:0] state_d;
  logic       step;
  logic       up;
  logic       illegal;
  logic       cnt_en_n_d;
  logic       u_dn_d;
  logic       load_n_d;
  logic       error_d;

  // Position of a phase pair in the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // Two-flop synchronisers and the per-channel run-length filter.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      valid <= '0;
      run   <= '0;
    end else begin
      sync1 <= {PHASE_A, PHASE_B};
      sync2 <= sync1;
      for (int ch = 0; ch < 2; ch++) begin
        if (!valid[ch]) begin
          // Before the first accepted level, filt tracks the current candidate level.
          if (sync2[ch] != filt[ch]) begin
            filt[ch] <= sync2[ch];
            if (FILT_ONE) begin
              valid[ch] <= 1'b1;
              run[ch]   <= '0;
            end else begin
              run[ch] <= RUN_W'(1);
            end
          end else if (run[ch] + RUN_W'(1) >= FILT_MAX) begin
            valid[ch] <= 1'b1;
            run[ch]   <= '0;
          end else begin
            run[ch] <= run[ch] + RUN_W'(1);
          end
        end else if (sync2[ch] == filt[ch]) begin
          run[ch] <= '0;
        end else if (run[ch] + RUN_W'(1) >= FILT_MAX) begin
          filt[ch] <= sync2[ch];
          run[ch]  <= '0;
        end else begin
          run[ch] <= run[ch] + RUN_W'(1);
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= ST_INIT;
      CNT_ENn <= 1'b1;
      U_Dn    <= 1'b1;
      LOADn   <= 1'b1;
      ERROR   <= 1'b0;
    end else begin
      state   <= state_d;
      CNT_ENn <= cnt_en_n_d;
      U_Dn    <= u_dn_d;
      LOADn   <= load_n_d;
      ERROR   <= error_d;
    end
  end

  // Next-state decode; a CLEAR in the same cycle discards the step but not the move.
  always_comb begin
    state_d = state;
    step    = 1'b0;
    up      = 1'b0;
    illegal = 1'b0;
    if (state == ST_INIT) begin
      if (&valid) state_d = {1'b0, filt};
    end else if (filt != state[1:0]) begin
      state_d = {1'b0, filt};
      if ((filt ^ state[1:0]) == 2'b11) begin
        illegal = 1'b1;
      end else begin
        step = 1'b1;
        up   = (gray_idx(filt) == gray_idx(state[1:0]) + 2'd1);
      end
    end
    load_n_d   = ~CLEAR;
    cnt_en_n_d = ~(step & ~CLEAR);
    u_dn_d     = (step & ~CLEAR) ? up : U_Dn;
    error_d    = illegal | (ERROR & ~ERR_CLR);
  end

endmodule
